circle_plotter: RTL and testbench
=================================

# circle_plotter

Midpoint (Bresenham) circle rasteriser that sits directly upstream of the VGA adapter in the 160x120 demo designs. On a start pulse it latches a centre, radius and colour, then emits one pixel per clock on x/y/colour/plot, which connect straight to the adapter's pixel-write port. Pixels falling off-screen are clipped by holding plot low. A one-cycle done pulse lets a top-level FSM sequence several shapes or fall back to an idle state.

## Interface
- XMAX, 159, rightmost visible column
- YMAX, 119, bottom visible row
- CLOCK_50  input  1  system clock, all logic on rising edge
- resetn  input  1  synchronous, active-low reset
- start  input  1  request to draw; sampled only in IDLE
- cx  input  8  centre column, 0..255 accepted, unsigned
- cy  input  7  centre row, unsigned
- radius  input  7  radius in pixels, 0..127
- colour_in  input  3  RGB colour for this circle
- x  output  8  pixel column to adapter
- y  output  7  pixel row to adapter
- colour  output  3  pixel colour to adapter (latched colour_in)
- plot  output  1  write strobe to adapter
- busy  output  1  high from the cycle after start acceptance until DONE
- done  output  1  one-cycle pulse when the circle is complete

## Operation
- Reset: state IDLE; x=0, y=0, colour=0, plot=0, busy=0, done=0; internal registers cleared.
- States: IDLE, INIT, PLOT, STEP, DONE.
- IDLE: if start=1, latch cx, cy, radius, colour_in -> INIT. start while not in IDLE is ignored; it is not queued.
- INIT (1 cycle): ox=radius, oy=0, crit=1-radius, oct=0 -> PLOT.
- PLOT (8 cycles, oct=0..7): candidate pixel by octant:
  - 0:(cx+ox,cy+oy)
  - 1:(cx+oy,cy+ox)
  - 2:(cx-ox,cy+oy)
  - 3:(cx-oy,cy+ox)
  - 4:(cx-ox,cy-oy)
  - 5:(cx-oy,cy-ox)
  - 6:(cx+ox,cy-oy)
  - 7:(cx+oy,cy-ox)
  - After oct=7 -> STEP.
- Clipping: compute the candidate in 10-bit signed. plot=1 only if 0<=px<=XMAX and 0<=py<=YMAX; otherwise plot=0 and the cycle is still consumed. x/y carry the low 8/7 bits of the candidate regardless.
- STEP (1 cycle): oy<=oy+1.
  - If crit<=0: crit<=crit+2*(oy+1)+1.
  - Else: ox<=ox-1 and crit<=crit+2*((oy+1)-(ox-1))+1.
  - Then if new oy<=new ox -> PLOT with oct=0, else -> DONE.
- DONE (1 cycle): done=1, busy=0 -> IDLE.
- Arithmetic: ox, oy 8-bit unsigned; crit 10-bit signed. No overflow for radius<=127.
- Duplicate pixels at octant seams (e.g. oy=0, ox=oy) are emitted, not suppressed.

## Timing
- x, y, colour and plot are registered; the pixel for PLOT cycle k is on the outputs during that cycle.
- With start sampled at edge t: INIT occupies cycle t+1, the first PLOT cycle is t+2, and each iteration takes 9 cycles (8 PLOT + 1 STEP).
- For N iterations, done=1 at cycle t+2+9N and is high for exactly one cycle. busy is high from t+1 through t+1+9N.
- plot=0 in every state except PLOT.
- resetn low mid-draw: the next edge forces IDLE with all outputs at reset values; no further plot.
- start held high continuously: a new circle is accepted on the first IDLE cycle after DONE, using the input values present then.

## Test plan
- Reset: hold resetn=0 for 3 cycles with start=1 -> plot=0, busy=0, done=0, x=0, y=0 throughout.
- radius=0, centre (80,60), colour 3'b101 -> exactly 8 plot pulses, all at x=80, y=60, colour=5; done at start+11.
- radius=1, centre (10,10) -> N=2, 16 plot pulses.
  - First 8 are (11,10), (10,11), (9,10), (10,11), (9,10), (10,9), (11,10), (10,9).
  - Next 8 are the four diagonals (11,11), (9,11), (9,9), (11,9), each twice.
  - done at start+20.
- radius=5, centre (0,0) -> no plot pulse with a candidate coordinate <0; every plotted pixel satisfies x^2+y^2 within ±5 of 25. Total cycle count matches 2+9N.
- start pulsed again at start+5 during a radius=10 draw -> ignored; exactly one done pulse.
- resetn asserted at start+15 of a radius=20 draw -> next cycle busy=0 and plot=0. A fresh start then completes normally.

Source files
------------

// File: rtl/circle_plotter.sv
// Midpoint circle rasteriser feeding the 160x120 VGA adapter pixel-write port.
// Emits one candidate pixel per clock; off-screen candidates are clipped by holding plot low.
module circle_plotter #(
  parameter int XMAX = 159,
  parameter int YMAX = 119
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] cx,
  input  logic [6:0] cy,
  input  logic [6:0] radius,
  input  logic [2:0] colour_in,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_PLOT, S_STEP, S_DONE} state_t;

  localparam logic signed [9:0] XMAX_S = 10'(XMAX);
  localparam logic signed [9:0] YMAX_S = 10'(YMAX);

  state_t            r_state;
  logic [7:0]        r_cx;
  logic [6:0]        r_cy;
  logic [7:0]        r_ox;
  logic [7:0]        r_oy;
  logic signed [9:0] r_crit;
  logic [2:0]        r_oct;

  logic signed [9:0] w_ox_cur;
  logic signed [9:0] w_oy_cur;
  logic signed [9:0] w_ox_nx;
  logic signed [9:0] w_oy_nx;
  logic signed [9:0] w_diff;
  logic signed [9:0] w_crit_nx;
  logic              w_crit_le0;
  logic              w_continue;

  // Midpoint decision step; ox may go to -1 here, which is what ends a radius-0 circle.
  always_comb begin
    w_ox_cur   = $signed({2'b00, r_ox});
    w_oy_cur   = $signed({2'b00, r_oy});
    w_crit_le0 = (r_crit <= 10'sd0);
    w_oy_nx    = w_oy_cur + 10'sd1;
    w_ox_nx    = w_crit_le0 ? w_ox_cur : w_ox_cur - 10'sd1;
    w_diff     = w_crit_le0 ? w_oy_nx : w_oy_nx - w_ox_nx;
    w_crit_nx  = r_crit + w_diff + w_diff + 10'sd1;
    w_continue = (w_oy_nx <= w_ox_nx);
  end

  logic [2:0]        w_pix_oct;
  logic signed [9:0] w_a;
  logic signed [9:0] w_b;
  logic signed [9:0] w_cxs;
  logic signed [9:0] w_cys;
  logic signed [9:0] w_px;
  logic signed [9:0] w_py;
  logic              w_vis;

  // NOTE: the pixel is built from the values the state machine is about to hold, so the
  // registered x/y/plot line up with the PLOT cycle they belong to rather than one cycle late.
  always_comb begin
    w_pix_oct = (r_state == S_PLOT) ? r_oct + 3'd1 : 3'd0;
    if (r_state == S_STEP) begin
      w_a = w_ox_nx;
      w_b = w_oy_nx;
    end else begin
      w_a = w_ox_cur;
      w_b = w_oy_cur;
    end
    w_cxs = $signed({2'b00, r_cx});
    w_cys = $signed({3'b000, r_cy});
    w_px  = w_cxs;
    w_py  = w_cys;
    case (w_pix_oct)
      3'd0: begin w_px = w_cxs + w_a; w_py = w_cys + w_b; end
      3'd1: begin w_px = w_cxs + w_b; w_py = w_cys + w_a; end
      3'd2: begin w_px = w_cxs - w_a; w_py = w_cys + w_b; end
      3'd3: begin w_px = w_cxs - w_b; w_py = w_cys + w_a; end
      3'd4: begin w_px = w_cxs - w_a; w_py = w_cys - w_b; end
      3'd5: begin w_px = w_cxs - w_b; w_py = w_cys - w_a; end
      3'd6: begin w_px = w_cxs + w_a; w_py = w_cys - w_b; end
      3'd7: begin w_px = w_cxs + w_b; w_py = w_cys - w_a; end
      default: begin w_px = w_cxs; w_py = w_cys; end
    endcase
    w_vis = (w_px >= 10'sd0) && (w_px <= XMAX_S) && (w_py >= 10'sd0) && (w_py <= YMAX_S);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cx    <= '0;
      r_cy    <= '0;
      r_ox    <= '0;
      r_oy    <= '0;
      r_crit  <= '0;
      r_oct   <= '0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      plot    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cx    <= cx;
            r_cy    <= cy;
            r_ox    <= {1'b0, radius};
            r_oy    <= '0;
            r_crit  <= 10'sd1 - $signed({3'b000, radius});
            r_oct   <= '0;
            colour  <= colour_in;
            busy    <= 1'b1;
            r_state <= S_INIT;
          end
        end
        S_INIT: begin
          r_oct   <= '0;
          x       <= w_px[7:0];
          y       <= w_py[6:0];
          plot    <= w_vis;
          r_state <= S_PLOT;
        end
        S_PLOT: begin
          if (r_oct == 3'd7) begin
            r_state <= S_STEP;
          end else begin
            r_oct <= r_oct + 3'd1;
            x     <= w_px[7:0];
            y     <= w_py[6:0];
            plot  <= w_vis;
          end
        end
        S_STEP: begin
          r_ox   <= w_ox_nx[7:0];
          r_oy   <= w_oy_nx[7:0];
          r_crit <= w_crit_nx;
          if (w_continue) begin
            r_oct   <= '0;
            x       <= w_px[7:0];
            y       <= w_py[6:0];
            plot    <= w_vis;
            r_state <= S_PLOT;
          end else begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_circle_plotter.sv
// Scoreboard bench for circle_plotter: expected visible pixels are queued when a circle
// is launched and popped by a monitor on every plot strobe.
module tb_circle_plotter;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] cx = '0;
  logic [6:0] cy = '0;
  logic [6:0] radius = '0;
  logic [2:0] colour_in = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  circle_plotter dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .start    (start),
    .cx       (cx),
    .cy       (cy),
    .radius   (radius),
    .colour_in(colour_in),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pix_seen = 0;
  bit   ring_on = 1'b0;
  pix_t mon_e;
  int   mon_d;

  // Scoreboard monitor: every plot strobe must match the next expected visible pixel.
  always @(negedge CLOCK_50) begin
    if (plot === 1'b1) begin
      pix_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pixel: got (%0d,%0d) colour %0d, required no plot", x, y, colour);
      end else begin
        mon_e = exp_q.pop_front();
        if ({x, y, colour} !== {mon_e.x, mon_e.y, mon_e.c}) begin
          errors++;
          $display("FAIL pixel: got (%0d,%0d) colour %0d, required (%0d,%0d) colour %0d",
                   x, y, colour, mon_e.x, mon_e.y, mon_e.c);
        end
      end
      if (ring_on) begin
        checks++;
        mon_d = int'(x) * int'(x) + int'(y) * int'(y) - 25;
        if (mon_d < -5 || mon_d > 5) begin
          errors++;
          $display("FAIL ring_radius5: got (%0d,%0d) r^2 off by %0d, required within 5", x, y, mon_d);
        end
      end
    end
  end

  task automatic push_pix(input int px, input int py, input logic [2:0] c);
    pix_t p;
    p.x = 8'(px);
    p.y = 7'(py);
    p.c = c;
    exp_q.push_back(p);
  endtask

  // Reference midpoint algorithm in plain integers; queues only on-screen pixels.
  task automatic model_circle(input int c_x, input int c_y, input int r, input logic [2:0] col,
                              output int n);
    int ox, oy, crit, px, py;
    ox = r; oy = 0; crit = 1 - r; n = 0;
    do begin
      n++;
      for (int o = 0; o < 8; o++) begin
        case (o)
          0: begin px = c_x + ox; py = c_y + oy; end
          1: begin px = c_x + oy; py = c_y + ox; end
          2: begin px = c_x - ox; py = c_y + oy; end
          3: begin px = c_x - oy; py = c_y + ox; end
          4: begin px = c_x - ox; py = c_y - oy; end
          5: begin px = c_x - oy; py = c_y - ox; end
          6: begin px = c_x + ox; py = c_y - oy; end
          default: begin px = c_x + oy; py = c_y - ox; end
        endcase
        if (px >= 0 && px <= 159 && py >= 0 && py <= 119) push_pix(px, py, col);
      end
      oy = oy + 1;
      if (crit <= 0) crit = crit + 2 * oy + 1;
      else begin
        ox = ox - 1;
        crit = crit + 2 * (oy - ox) + 1;
      end
    end while (oy <= ox);
  endtask

  // Presents inputs with start high for exactly one sampling edge (edge t); returns just after it.
  task automatic launch(input logic [7:0] c_x, input logic [6:0] c_y, input logic [6:0] r,
                        input logic [2:0] col);
    @(posedge CLOCK_50); #1;
    start = 1'b1; cx = c_x; cy = c_y; radius = r; colour_in = col;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
  endtask

  // Counts cycles after edge t until done (bounded); k-th negedge lies in cycle t+k.
  task automatic wait_done(input int pulse_at, input bit hold, output int done_k,
                           output int busy_hi, output logic busy_at_done);
    done_k = -1; busy_hi = 0; busy_at_done = 1'b1;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge CLOCK_50);
      if (done === 1'b1) begin
        done_k = k;
        busy_at_done = busy;
        break;
      end
      if (busy === 1'b1) busy_hi++;
      start = hold || (k == pulse_at);
    end
    start = hold;
  endtask

  task automatic test_reset;
    resetn = 1'b0; start = 1'b1; cx = 8'd80; cy = 7'd60; radius = 7'd10; colour_in = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK_50);
      checks++;
      if ({plot, busy, done, x, y, colour} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d: plot=%b busy=%b done=%b x=%0d y=%0d colour=%0d, required all 0",
                 i, plot, busy, done, x, y, colour);
      end
    end
    start = 1'b0;
    resetn = 1'b1;
    @(negedge CLOCK_50);
    checks++;
    if (busy !== 1'b0 || plot !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b plot=%b, required 0 0", busy, plot);
    end
  endtask

  task automatic test_radius0;
    int n0, dk, bh;
    logic bd;
    for (int i = 0; i < 8; i++) push_pix(80, 60, 3'b101);
    n0 = pix_seen;
    launch(8'd80, 7'd60, 7'd0, 3'b101);
    wait_done(-1, 1'b0, dk, bh, bd);
    checks++;
    if (dk != 11) begin errors++; $display("FAIL r0_done_cycle: got %0d, required 11", dk); end
    checks++;
    if (bh != 10) begin errors++; $display("FAIL r0_busy_cycles: got %0d, required 10", bh); end
    checks++;
    if (bd !== 1'b0) begin errors++; $display("FAIL r0_busy_at_done: got %b, required 0", bd); end
    checks++;
    if (pix_seen - n0 != 8) begin errors++; $display("FAIL r0_plot_count: got %0d, required 8", pix_seen - n0); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL r0_missing_pixels: got %0d left, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_radius1;
    int n0, dk, bh;
    logic bd;
    push_pix(11, 10, 3'b010); push_pix(10, 11, 3'b010); push_pix(9, 10, 3'b010); push_pix(10, 11, 3'b010);
    push_pix(9, 10, 3'b010);  push_pix(10, 9, 3'b010);  push_pix(11, 10, 3'b010); push_pix(10, 9, 3'b010);
    push_pix(11, 11, 3'b010); push_pix(11, 11, 3'b010); push_pix(9, 11, 3'b010);  push_pix(9, 11, 3'b010);
    push_pix(9, 9, 3'b010);   push_pix(9, 9, 3'b010);   push_pix(11, 9, 3'b010);  push_pix(11, 9, 3'b010);
    n0 = pix_seen;
    launch(8'd10, 7'd10, 7'd1, 3'b010);
    wait_done(-1, 1'b0, dk, bh, bd);
    checks++;
    if (dk != 20) begin errors++; $display("FAIL r1_done_cycle: got %0d, required 20", dk); end
    checks++;
    if (bh != 19) begin errors++; $display("FAIL r1_busy_cycles: got %0d, required 19", bh); end
    checks++;
    if (pix_seen - n0 != 16) begin errors++; $display("FAIL r1_plot_count: got %0d, required 16", pix_seen - n0); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL r1_missing_pixels: got %0d left, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_clip_corner;
    int n, n0, want, dk, bh;
    logic bd;
    model_circle(0, 0, 5, 3'b001, n);
    want = exp_q.size();
    n0 = pix_seen;
    ring_on = 1'b1;
    launch(8'd0, 7'd0, 7'd5, 3'b001);
    wait_done(-1, 1'b0, dk, bh, bd);
    ring_on = 1'b0;
    checks++;
    if (dk != 2 + 9 * n) begin errors++; $display("FAIL clip_done_cycle: got %0d, required %0d", dk, 2 + 9 * n); end
    checks++;
    if (pix_seen - n0 != want) begin errors++; $display("FAIL clip_plot_count: got %0d, required %0d", pix_seen - n0, want); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL clip_missing_pixels: got %0d left, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_ignore_start;
    int n, dk, bh, extra_done, extra_busy;
    logic bd;
    model_circle(80, 60, 10, 3'b100, n);
    launch(8'd80, 7'd60, 7'd10, 3'b100);
    wait_done(5, 1'b0, dk, bh, bd);
    extra_done = 0; extra_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50);
      if (done === 1'b1) extra_done++;
      if (busy === 1'b1) extra_busy++;
    end
    checks++;
    if (dk != 2 + 9 * n) begin errors++; $display("FAIL ignore_done_cycle: got %0d, required %0d", dk, 2 + 9 * n); end
    checks++;
    if (bh != 1 + 9 * n) begin errors++; $display("FAIL ignore_busy_cycles: got %0d, required %0d", bh, 1 + 9 * n); end
    checks++;
    if (extra_done != 0 || extra_busy != 0) begin
      errors++;
      $display("FAIL ignore_second_draw: got %0d done / %0d busy cycles after done, required 0 0", extra_done, extra_busy);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL ignore_missing_pixels: got %0d left, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back;
    int n1, n2, dk, bh;
    logic bd;
    model_circle(50, 50, 2, 3'b110, n1);
    @(posedge CLOCK_50); #1;
    start = 1'b1; cx = 8'd50; cy = 7'd50; radius = 7'd2; colour_in = 3'b110;
    @(posedge CLOCK_50); #1;
    wait_done(-1, 1'b1, dk, bh, bd);
    checks++;
    if (dk != 2 + 9 * n1) begin errors++; $display("FAIL b2b_first_done: got %0d, required %0d", dk, 2 + 9 * n1); end
    cx = 8'd60;
    model_circle(60, 50, 2, 3'b110, n2);
    @(negedge CLOCK_50);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap: busy=%b done=%b, required 0 0", busy, done);
    end
    @(negedge CLOCK_50);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_reaccept: busy=%b, required 1", busy); end
    start = 1'b0;
    wait_done(-1, 1'b0, dk, bh, bd);
    checks++;
    if (dk != 1 + 9 * n2) begin errors++; $display("FAIL b2b_second_done: got %0d, required %0d", dk, 1 + 9 * n2); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing_pixels: got %0d left, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_draw;
    int n, dk, bh;
    logic bd;
    model_circle(80, 60, 20, 3'b011, n);
    launch(8'd80, 7'd60, 7'd20, 3'b011);
    for (int k = 1; k <= 15; k++) @(negedge CLOCK_50);
    resetn = 1'b0;
    @(negedge CLOCK_50);
    checks++;
    if ({plot, busy, done, x, y, colour} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: plot=%b busy=%b done=%b x=%0d y=%0d colour=%0d, required all 0",
               plot, busy, done, x, y, colour);
    end
    exp_q.delete();
    @(negedge CLOCK_50);
    resetn = 1'b1;
    @(negedge CLOCK_50);
    checks++;
    if (plot !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_stays_idle: plot=%b busy=%b, required 0 0", plot, busy);
    end
    model_circle(80, 60, 20, 3'b011, n);
    launch(8'd80, 7'd60, 7'd20, 3'b011);
    wait_done(-1, 1'b0, dk, bh, bd);
    checks++;
    if (dk != 2 + 9 * n) begin errors++; $display("FAIL midreset_fresh_done: got %0d, required %0d", dk, 2 + 9 * n); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL midreset_missing_pixels: got %0d left, required 0", exp_q.size()); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_radius0();
    test_radius1();
    test_clip_corner();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_draw();
    repeat (3) @(negedge CLOCK_50);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
